fpaddsub_result_stage: RTL and testbench
========================================

// Module: fpaddsub_result_stage
// PURPOSE
//  Output stage directly downstream of the FP add/sub exception stage.
//  - Registers the final 32-bit result and its 5-bit flag vector through a 2-entry buffer with valid/ready handshake.
//  - Accumulates IEEE-754 sticky status flags.
//  - Keeps one saturating event counter per flag, readable through a select port.
// PARAMETERS
//  WORD_W   32  result width (sign|exp[30:23]|mant[22:0])
//  FLAG_W   5   flag width, layout {Overflow,Underflow,DivideByZero,Invalid,Inexact} = bits [4:0]
//  DEPTH    2   buffer entries (fixed at 2; other values unsupported)
//  CNT_W    16  per-flag event counter width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  in_valid    in   1       upstream result/flags valid
//  in_ready    out  1       stage can accept this cycle
//  in_p        in   WORD_W  final result from exception stage
//  in_flags    in   FLAG_W  exception flags from exception stage
//  out_valid   out  1       res_p/res_flags valid
//  out_ready   in   1       consumer accepts this cycle
//  res_p       out  WORD_W  buffered result (head entry)
//  res_flags   out  FLAG_W  buffered flags (head entry)
//  clr_sticky  in   1       synchronous clear of sticky flags and counters
//  sticky      out  FLAG_W  OR of flags of all accepted results since reset/clear
//  cnt_sel     in   3       counter select, 0..4 = flag bit index
//  cnt_rd      out  CNT_W   selected counter value
// BEHAVIOUR
//  Reset (async, immediate):
//  - occupancy=0, out_valid=0, res_p=0, res_flags=0, sticky=0, all counters=0.
//  - in_ready=1 from the first clk edge after rst deasserts.
//  Handshake:
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (occupancy != DEPTH). It is a function of registered state only; no comb path from out_ready.
//  - out_valid = (occupancy != 0). Outputs are driven from the head register only.
//  - Data must not change while out_valid & ~out_ready.
//  - Latency 1: a push at edge N is visible on res_p at edge N+1 when the buffer was empty.
//  - Sustains 1 result/cycle while out_ready=1.
//  Occupancy transitions (push,pop):
//  - (1,0): +1.
//  - (0,1): -1.
//  - (1,1): unchanged; head advances and tail is written.
//  - Full plus simultaneous pop: in_ready=0 that cycle, so no push occurs; occupancy 2->1.
//  - Empty: pop is impossible since out_valid=0; a push lands in the head register.
//  - FIFO order is strict; entries never reorder or duplicate.
//  - In_valid with in_ready=0 is a stall; upstream holds its data.
//  Sticky flags:
//  - On push, sticky <= sticky | in_flags.
//  - On clr_sticky without push, sticky <= 0.
//  - On clr_sticky with push, sticky <= in_flags (the new event survives the clear).
//  Counters cnt[i], i=0..4:
//  - On push with in_flags[i]=1, cnt[i] <= cnt[i]+1, saturating at 2^CNT_W-1 (no wrap).
//  - On clr_sticky without push, cnt[i] <= 0.
//  - On clr_sticky with push and in_flags[i]=1, cnt[i] <= 1.
//  - cnt_rd = cnt[cnt_sel], combinational mux of registers; cnt_sel 5..7 reads 0.
//  Statistics follow accept (push), not delivery (pop).
//  rst mid-stream discards buffered entries; no partial state survives.
// STRUCTURE
//  fpaddsub_pkg (shared):
//  - WORD_W, FLAG_W localparams.
//  - FLAG_OVF=4, FLAG_UNF=3, FLAG_DBZ=2, FLAG_INV=1, FLAG_INX=0 indices.
//  - Reused by the exception stage and this stage.
//  Sub-module fpaddsub_skid_fifo:
//  - 2-entry valid/ready buffer, width WORD_W+FLAG_W.
//  - Owns occupancy, head/tail registers and in_ready/out_valid.
//  Top level holds the sticky register, the 5 saturating counters and the cnt_rd mux.
// TESTING
//  1 Reset: rst=1 mid-traffic with 2 entries held
//    -> out_valid=0, res_p=0, sticky=0, cnt_rd=0 immediately; in_ready=1 after release.
//  2 Streaming: push 0x3F800000, 0x40000000, 0x40400000 (flags 0) with out_ready=1
//    -> outputs emerge one per cycle in order, latency 1, in_ready stays 1.
//  3 Backpressure: out_ready=0, push 3 results
//    -> only 2 accepted, in_ready=0; then out_ready=1
//    -> both drain in order, third accepted, no loss or duplication.
//  4 Sticky/clear: push flags 5'b00001, then 5'b10001 -> sticky=5'b10001.
//    Then clr_sticky with push of flags 5'b01000 -> sticky=5'b01000, cnt[3]=1, cnt[0]=0.
//  5 Saturation: CNT_W=4, push 17 results with Inexact=1
//    -> cnt_rd(sel=0)=15, no wrap; cnt_sel=6 -> cnt_rd=0.
//  6 Randomised valid/ready vs scoreboard: ordering, occupancy<=2, no comb out_ready->in_ready path (checked by assertion).

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the FP add/sub pipeline: word/flag widths, flag bit
// indices and the buffered result record.
package fpaddsub_pkg;

  localparam int WORD_W = 32;
  localparam int FLAG_W = 5;
  localparam int DEPTH  = 2;

  localparam int FLAG_OVF = 4;
  localparam int FLAG_UNF = 3;
  localparam int FLAG_DBZ = 2;
  localparam int FLAG_INV = 1;
  localparam int FLAG_INX = 0;

  typedef struct packed {
    logic [WORD_W-1:0] p;
    logic [FLAG_W-1:0] flags;
  } result_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fpaddsub_result_stage_if.sv
// Upstream/downstream valid-ready bundle of the result stage; the stage sees
// the slave view, whoever feeds and drains it uses the master view.
interface fpaddsub_result_stage_if;
  import fpaddsub_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_p;
  logic [FLAG_W-1:0] in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] res_p;
  logic [FLAG_W-1:0] res_flags;

  modport slave (
    input  in_valid, in_p, in_flags, out_ready,
    output in_ready, out_valid, res_p, res_flags
  );

  modport master (
    output in_valid, in_p, in_flags, out_ready,
    input  in_ready, out_valid, res_p, res_flags
  );

endinterface

// File: rtl/fpaddsub_skid_fifo.sv
// Two-entry valid/ready buffer. Output is always the head register; in_ready
// depends on registered state only, so there is no out_ready -> in_ready path.
module fpaddsub_skid_fifo
  import fpaddsub_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  result_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output result_t out_data
);

  occ_e    state, state_nxt;
  result_t head, tail;
  logic    ready_en;
  logic    push, pop;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = head;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OCC_EMPTY;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_nxt unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OCC_EMPTY: if (push) state_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_nxt = OCC_FULL;
        else if (pop && !push) state_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_nxt = OCC_ONE;
      default:   state_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = ready_en && (state != OCC_FULL);
    out_valid = (state != OCC_EMPTY);
  end

  // NOTE: the two entries are reset too, because the head register drives
  // res_p directly and must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        OCC_EMPTY: if (push) head <= in_data;
        OCC_ONE: begin
          if (push && pop) head <= in_data;
          else if (push)   tail <= in_data;
        end
        // Full means in_ready=0, so a pop here never coincides with a push.
        OCC_FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpaddsub_result_stage.sv
// Output stage after the FP add/sub exception stage: buffers result+flags,
// accumulates sticky IEEE flags and keeps one saturating counter per flag.
module fpaddsub_result_stage
  import fpaddsub_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fpaddsub_result_stage_if.slave  bus,
  input  logic                    clr_sticky,
  output logic [FLAG_W-1:0]       sticky,
  input  logic [2:0]              cnt_sel,
  output logic [CNT_W-1:0]        cnt_rd
);

  result_t          fifo_in, fifo_out;
  logic             fifo_in_ready;
  logic             push;
  logic [CNT_W-1:0] cnt [FLAG_W];

  assign fifo_in  = '{p: bus.in_p, flags: bus.in_flags};
  assign push     = bus.in_valid & fifo_in_ready;

  assign bus.in_ready  = fifo_in_ready;
  assign bus.res_p     = fifo_out.p;
  assign bus.res_flags = fifo_out.flags;

  fpaddsub_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_out)
  );

  // Statistics follow accept; a push coinciding with a clear survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sticky <= '0;
    else if (clr_sticky) sticky <= push ? bus.in_flags : '0;
    else if (push)       sticky <= sticky | bus.in_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLAG_W; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (clr_sticky)
          cnt[i] <= (push && bus.in_flags[i]) ? CNT_W'(1) : '0;
        else if (push && bus.in_flags[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Selects beyond the last flag read zero.
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < FLAG_W; i++)
      if (cnt_sel == 3'(i)) cnt_rd = cnt[i];
  end

endmodule

// File: tb/tb_fpaddsub_result_stage.sv
// Directed bench for fpaddsub_result_stage with a small queue model for the
// randomised valid/ready phase; counters built 4 bits wide to reach saturation.
module tb_fpaddsub_result_stage;
  import fpaddsub_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_sticky;
  logic [FLAG_W-1:0] sticky;
  logic [2:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_rd;

  int checks = 0;
  int errors = 0;

  fpaddsub_result_stage_if bus ();

  fpaddsub_result_stage #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky     (sticky),
    .cnt_sel    (cnt_sel),
    .cnt_rd     (cnt_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WORD_W+FLAG_W-1:0] q [$];
  logic push, pop, stalled;

  initial begin
    rst           = 1'b1;
    clr_sticky    = 1'b0;
    cnt_sel       = 3'd0;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_flags  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res_p",     bus.res_p,          32'h0);
    check("rst_sticky",    32'(sticky),        32'd0);
    check("rst_cnt_rd",    32'(cnt_rd),        32'd0);
    rst = 1'b0;
    step();
    check("rel_in_ready",  32'(bus.in_ready),  32'd1);

    // Streaming, latency 1, one result per cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_p      = 32'h3F80_0000;
    step();
    check("str0_res_p",    bus.res_p,          32'h3F80_0000);
    check("str0_valid",    32'(bus.out_valid), 32'd1);
    check("str0_in_ready", 32'(bus.in_ready),  32'd1);
    bus.in_p = 32'h4000_0000;
    step();
    check("str1_res_p",    bus.res_p,          32'h4000_0000);
    check("str1_in_ready", 32'(bus.in_ready),  32'd1);
    bus.in_p = 32'h4040_0000;
    step();
    check("str2_res_p",    bus.res_p,          32'h4040_0000);
    check("str2_in_ready", 32'(bus.in_ready),  32'd1);
    bus.in_valid = 1'b0;
    step();
    check("str_drained",   32'(bus.out_valid), 32'd0);

    // Backpressure: only two accepted, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_p      = 32'h1111_1111;
    step();
    check("bp_d_res_p",    bus.res_p,          32'h1111_1111);
    check("bp_d_in_ready", 32'(bus.in_ready),  32'd1);
    bus.in_p = 32'h2222_2222;
    step();
    check("bp_full_ready", 32'(bus.in_ready),  32'd0);
    check("bp_full_head",  bus.res_p,          32'h1111_1111);
    bus.in_p = 32'h3333_3333;
    step();
    check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
    check("bp_stall_head", bus.res_p,          32'h1111_1111);
    bus.out_ready = 1'b1;
    step();
    check("bp_pop1_res_p", bus.res_p,          32'h2222_2222);
    check("bp_pop1_ready", 32'(bus.in_ready),  32'd1);
    step();
    check("bp_pop2_res_p", bus.res_p,          32'h3333_3333);
    check("bp_pop2_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("bp_empty",      32'(bus.out_valid), 32'd0);

    // Reset mid-traffic with two entries held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_p      = 32'hAAAA_0001;
    bus.in_flags  = 5'b00010;
    cnt_sel       = 3'd1;
    step();
    bus.in_p     = 32'hAAAA_0002;
    bus.in_flags = 5'b00000;
    step();
    check("pre_rst_sticky", 32'(sticky),       32'h02);
    check("pre_rst_cnt1",  32'(cnt_rd),        32'd1);
    check("pre_rst_ready", 32'(bus.in_ready),  32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_res_p", bus.res_p,          32'h0);
    check("mid_rst_sticky", 32'(sticky),       32'd0);
    check("mid_rst_cnt",   32'(cnt_rd),        32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Sticky accumulate, clear-with-push, clear-without-push
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_p      = 32'h0000_0001;
    bus.in_flags  = 5'b00001;
    step();
    bus.in_flags = 5'b10001;
    step();
    bus.in_valid = 1'b0;
    check("stk_or",        32'(sticky),        32'h11);
    cnt_sel = 3'd0; #1;
    check("stk_cnt0",      32'(cnt_rd),        32'd2);
    cnt_sel = 3'd4; #1;
    check("stk_cnt4",      32'(cnt_rd),        32'd1);
    clr_sticky   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_flags = 5'b01000;
    step();
    clr_sticky   = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_push_sticky", 32'(sticky),      32'h08);
    cnt_sel = 3'd3; #1;
    check("clr_push_cnt3", 32'(cnt_rd),        32'd1);
    cnt_sel = 3'd0; #1;
    check("clr_push_cnt0", 32'(cnt_rd),        32'd0);
    cnt_sel = 3'd4; #1;
    check("clr_push_cnt4", 32'(cnt_rd),        32'd0);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_sticky",    32'(sticky),        32'd0);
    cnt_sel = 3'd3; #1;
    check("clr_cnt3",      32'(cnt_rd),        32'd0);

    // Saturation: 17 Inexact events into a 4-bit counter
    bus.in_valid = 1'b1;
    bus.in_flags = 5'b00001;
    for (int i = 0; i < 17; i++) begin
      bus.in_p = 32'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    cnt_sel = 3'd0; #1;
    check("sat_cnt0",      32'(cnt_rd),        32'd15);
    check("sat_sticky",    32'(sticky),        32'h01);
    cnt_sel = 3'd6; #1;
    check("sel6_zero",     32'(cnt_rd),        32'd0);
    cnt_sel = 3'd5; #1;
    check("sel5_zero",     32'(cnt_rd),        32'd0);

    // Randomised valid/ready against a queue model
    q.delete();
    stalled = 1'b0;
    for (int c = 0; c < 300; c++) begin
      check("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("rnd_in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
      if (q.size() != 0) begin
        check("rnd_res_p",     bus.res_p,          q[0][WORD_W+FLAG_W-1:FLAG_W]);
        check("rnd_res_flags", 32'(bus.res_flags), 32'(q[0][FLAG_W-1:0]));
      end
      if (!stalled) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_p     = $urandom;
        bus.in_flags = FLAG_W'($urandom_range(0, 31));
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      push = bus.in_valid && (q.size() < DEPTH);
      pop  = bus.out_ready && (q.size() != 0);
      bus.out_ready = ~bus.out_ready;
      #1;
      check("rnd_no_comb_path", 32'(bus.in_ready), 32'(q.size() < DEPTH));
      bus.out_ready = ~bus.out_ready;
      #1;
      step();
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({bus.in_p, bus.in_flags});
      stalled = bus.in_valid && !push;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
